// File: rtl/reg_op_sequencer.sv
// Micro-program sequencer for the 16 x 32-bit register-operation datapath.
// Issues stored op words on mode/rx/ry/rz and tracks the datapath carry.
module reg_op_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int PAW        = 4,
    parameter int RAW        = 4,
    parameter int MW         = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           prog_we,
    input  logic [PAW-1:0] prog_addr,
    input  logic [15:0]    prog_data,
    input  logic           start,
    input  logic           cy,
    output logic [MW-1:0]  mode,
    output logic [RAW-1:0] rx,
    output logic [RAW-1:0] ry,
    output logic [RAW-1:0] rz,
    output logic           busy,
    output logic           done,
    output logic [PAW-1:0] pc,
    output logic           carry_flag
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        ISSUE   = 3'd2,
        CAPTURE = 3'd3,
        DONE_ST = 3'd4
    } state_t;

    localparam logic [PAW-1:0] LAST_PC = PAW'(PROG_DEPTH - 1);
    localparam logic [3:0]     OP_NOP  = 4'h0;
    localparam logic [3:0]     OP_JC   = 4'hE;
    localparam logic [3:0]     OP_HALT = 4'hF;

    state_t      state;
    logic [15:0] mem [PROG_DEPTH];
    logic [15:0] word;
    logic [3:0]  op;
    logic        at_last;

    assign word    = mem[pc];
    assign op      = word[15:12];
    assign at_last = (pc == LAST_PC);

    // Program store: cleared by reset, writable only while the sequencer is idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PROG_DEPTH; i++) begin
                mem[i] <= 16'h0000;
            end
        end else if (prog_we && (state == IDLE)) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // Sequencer FSM with registered datapath controls and status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mode       <= '0;
            rx         <= '0;
            ry         <= '0;
            rz         <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pc         <= '0;
            carry_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        pc         <= '0;
                        carry_flag <= 1'b0;
                        busy       <= 1'b1;
                        state      <= FETCH;
                    end else begin
                        state <= IDLE;
                    end
                end
                FETCH: begin
                    case (op)
                        OP_HALT: begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE_ST;
                        end
                        OP_JC, OP_NOP: begin
                            // A taken branch is a jump, so the end-of-program rule never applies
                            if ((op == OP_JC) && carry_flag) begin
                                pc    <= word[PAW-1:0];
                                state <= FETCH;
                            end else if (at_last) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= DONE_ST;
                            end else begin
                                pc    <= pc + PAW'(1);
                                state <= FETCH;
                            end
                        end
                        default: begin
                            mode  <= MW'(op);
                            rx    <= RAW'(word[11:8]);
                            ry    <= RAW'(word[7:4]);
                            rz    <= RAW'(word[3:0]);
                            state <= ISSUE;
                        end
                    endcase
                end
                ISSUE: begin
                    mode  <= '0;
                    rx    <= '0;
                    ry    <= '0;
                    rz    <= '0;
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    carry_flag <= cy;
                    if (at_last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE_ST;
                    end else begin
                        pc    <= pc + PAW'(1);
                        state <= FETCH;
                    end
                end
                DONE_ST: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    mode  <= '0;
                    rx    <= '0;
                    ry    <= '0;
                    rz    <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Self-checking bench: a program-level interpreter predicts the per-cycle outputs
// of each run, and directed programs exercise ops, branches, halts and resets.
module tb_reg_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [15:0] prog_data;
    logic        start;
    logic        cy;
    logic [3:0]  mode, rx, ry, rz, pc;
    logic        busy, done, carry_flag;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] prog [16];
    int          n_exp;
    logic [3:0]  e_mode [256];
    logic [3:0]  e_rx   [256];
    logic [3:0]  e_ry   [256];
    logic [3:0]  e_rz   [256];
    logic [3:0]  e_pc   [256];
    logic        e_busy [256];
    logic        e_done [256];
    logic        e_cf   [256];
    logic        e_cap  [256];

    reg_op_sequencer dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .cy(cy), .mode(mode),
        .rx(rx), .ry(ry), .rz(rz), .busy(busy), .done(done), .pc(pc),
        .carry_flag(carry_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s idx=%0d actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] m, input logic [3:0] x, input logic [3:0] y,
                        input logic [3:0] z, input logic [3:0] p, input logic b,
                        input logic d, input logic c, input logic cap);
        e_mode[n_exp] = m; e_rx[n_exp] = x; e_ry[n_exp] = y; e_rz[n_exp] = z;
        e_pc[n_exp] = p; e_busy[n_exp] = b; e_done[n_exp] = d; e_cf[n_exp] = c;
        e_cap[n_exp] = cap;
        n_exp++;
    endtask

    // Interpret the program instruction by instruction, emitting one entry per cycle
    task automatic build_model(input logic cyv);
        int         p;
        logic       cf;
        logic       fin;
        logic [15:0] w;
        logic [3:0] pa;
        n_exp = 0; p = 0; cf = 1'b0; fin = 1'b0;
        for (int guard = 0; guard < 64 && !fin; guard++) begin
            w  = prog[p];
            pa = 4'(p);
            push(4'h0, 4'h0, 4'h0, 4'h0, pa, 1'b1, 1'b0, cf, 1'b0);
            if (w[15:12] == 4'hF) begin
                fin = 1'b1;
            end else if (w[15:12] == 4'hE && cf) begin
                p = int'(w[3:0]);
            end else begin
                if (w[15:12] != 4'hE && w[15:12] != 4'h0) begin
                    push(w[15:12], w[11:8], w[7:4], w[3:0], pa, 1'b1, 1'b0, cf, 1'b0);
                    push(4'h0, 4'h0, 4'h0, 4'h0, pa, 1'b1, 1'b0, cf, 1'b1);
                    cf = cyv;
                end
                if (p == 15) fin = 1'b1;
                else p = p + 1;
            end
        end
        pa = 4'(p);
        push(4'h0, 4'h0, 4'h0, 4'h0, pa, 1'b0, 1'b1, cf, 1'b0);
        push(4'h0, 4'h0, 4'h0, 4'h0, pa, 1'b0, 1'b0, cf, 1'b0);
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(posedge clk);
        #1 prog_we = 1'b0;
        prog[a] = d;
    endtask

    task automatic clear_mirror();
        for (int i = 0; i < 16; i++) prog[i] = 16'h0000;
    endtask

    // Run the loaded program; inj injects start+prog_we, rst_at aborts with a reset
    task automatic run(input logic cyv, input int inj, input int rst_at);
        build_model(cyv);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < n_exp; i++) begin
            @(negedge clk);
            check("mode", i, 32'(mode), 32'(e_mode[i]));
            check("rx", i, 32'(rx), 32'(e_rx[i]));
            check("ry", i, 32'(ry), 32'(e_ry[i]));
            check("rz", i, 32'(rz), 32'(e_rz[i]));
            check("pc", i, 32'(pc), 32'(e_pc[i]));
            check("busy", i, 32'(busy), 32'(e_busy[i]));
            check("done", i, 32'(done), 32'(e_done[i]));
            check("carry_flag", i, 32'(carry_flag), 32'(e_cf[i]));
            cy = e_cap[i] ? cyv : ~cyv;
            if (i == inj) begin
                start = 1'b1; prog_we = 1'b1; prog_addr = 4'd1; prog_data = 16'h2456;
            end else begin
                start = 1'b0; prog_we = 1'b0;
            end
            if (i == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_mode", i, 32'(mode), 32'd0);
                check("rst_rxyz", i, 32'({rx, ry, rz}), 32'd0);
                check("rst_busy_done", i, 32'({busy, done}), 32'd0);
                check("rst_pc", i, 32'(pc), 32'd0);
                check("rst_cf", i, 32'(carry_flag), 32'd0);
                @(negedge clk);
                rst = 1'b0;
                clear_mirror();
                break;
            end
        end
        start = 1'b0; prog_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; prog_we = 1'b0; prog_addr = 4'd0; prog_data = 16'h0000;
        start = 1'b0; cy = 1'b0;
        clear_mirror();
        repeat (2) @(negedge clk);
        check("reset_outputs", 0, 32'({mode, rx, ry, rz, pc, busy, done, carry_flag}), 32'd0);
        rst = 1'b0;

        // All-NOP program: 16 fetches then done with pc=15
        run(1'b0, -1, -1);
        check("pin_nop_len", 0, 32'(n_exp), 32'd18);
        check("pin_nop_done_pc", 16, 32'(e_pc[16]), 32'd15);

        // Straight-line program
        load(4'd0, 16'h189A); load(4'd1, 16'h2AB6); load(4'd2, 16'hF000);
        run(1'b1, -1, -1);
        check("pin_str_len", 0, 32'(n_exp), 32'd9);
        check("pin_str_op1", 1, 32'({e_mode[1], e_rx[1], e_ry[1], e_rz[1]}), 32'h189A);
        check("pin_str_op2", 4, 32'({e_mode[4], e_rx[4], e_ry[4], e_rz[4]}), 32'h2AB6);
        check("pin_str_done", 7, 32'(e_done[7]), 32'd1);
        check("pin_str_idle", 8, 32'(e_busy[8]), 32'd0);

        // Branch on carry, taken then not taken
        load(4'd0, 16'h1123); load(4'd1, 16'hE003); load(4'd2, 16'hF000);
        load(4'd3, 16'h2456); load(4'd4, 16'hF000);
        run(1'b1, -1, -1);
        check("pin_jc_taken_op2", 5, 32'({e_mode[5], e_rx[5], e_ry[5], e_rz[5]}), 32'h2456);
        check("pin_jc_taken_cf", 0, 32'(e_cf[n_exp-1]), 32'd1);
        run(1'b0, -1, -1);
        check("pin_jc_not_len", 0, 32'(n_exp), 32'd7);
        check("pin_jc_not_pc", 0, 32'(e_pc[n_exp-2]), 32'd2);

        // Requests during ISSUE are ignored; the same write in IDLE lands
        load(4'd1, 16'hF000);
        run(1'b0, 1, -1);
        run(1'b0, -1, -1);
        check("pin_ign_len", 0, 32'(n_exp), 32'd6);
        load(4'd1, 16'h2456);
        run(1'b1, -1, -1);
        check("pin_write_len", 0, 32'(n_exp), 32'd9);

        // Reset during ISSUE, then a fresh program runs from pc 0
        run(1'b0, -1, 1);
        run(1'b0, -1, -1);
        check("pin_cleared_len", 0, 32'(n_exp), 32'd18);
        load(4'd0, 16'h189A); load(4'd1, 16'h2AB6); load(4'd2, 16'hF000);
        run(1'b0, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_op_sequencer.md
Name: reg_op_sequencer

Overview:
- Micro-program sequencer that drives the 16 x 32-bit register-operation datapath (bit32Register).
- Holds a small loadable program of register-operation words and issues them one at a time on the datapath's Mode/Rx/Ry/Rz inputs.
- Captures the datapath carry after each operation and supports a branch-on-carry and a halt.
- Replaces hand-driven Mode/Rx/Ry/Rz stimulus with a start/done handshake.

Parameters:
- PROG_DEPTH, 16: number of program words. Must be a power of 2.
- PAW, 4: program address width, equal to log2(PROG_DEPTH).
- RAW, 4: register address width, covering 16 registers.
- MW, 4: Mode width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- prog_we  in  1  program write strobe; honoured only in IDLE.
- prog_addr  in  PAW  program write address.
- prog_data  in  16  program word: [15:12] op, [11:8] rx, [7:4] ry, [3:0] rz.
- start  in  1  begin execution at pc 0; honoured only in IDLE.
- cy  in  1  carry output from the register datapath.
- mode  out  MW  operation code to the datapath; 0 means no operation.
- rx  out  RAW  source register X address.
- ry  out  RAW  source register Y address.
- rz  out  RAW  destination register address.
- busy  out  1  high in FETCH, ISSUE and CAPTURE.
- done  out  1  one-cycle pulse in the DONE state.
- pc  out  PAW  current program counter.
- carry_flag  out  1  carry captured from the last datapath operation.

Behaviour:
- Reset (asynchronous):
  - state returns to IDLE.
  - mode, rx, ry, rz, pc, carry_flag, busy and done all go to 0.
  - All program words are cleared to 0 (NOP).
- Program memory:
  - Combinational read of mem[pc].
  - Synchronous write of mem[prog_addr] <= prog_data when prog_we=1 and state is IDLE.
  - prog_we in any other state is ignored.
- Opcodes:
  - 0 = NOP.
  - 1..13 = datapath operation, forwarded unchanged on mode.
  - 14 = JC: if carry_flag=1, pc <= word[3:0]; otherwise pc advances.
  - 15 = HALT.
- IDLE:
  - On start=1: pc <= 0, carry_flag <= 0, go to FETCH.
  - start=1 together with prog_we=1: the write completes first, then the sequencer starts.
- FETCH (1 cycle), decoding mem[pc]:
  - Datapath op: register mode/rx/ry/rz from the word, go to ISSUE.
  - NOP: advance pc, stay in FETCH.
  - JC taken: pc <= target, stay in FETCH.
  - JC not taken: advance pc, stay in FETCH.
  - HALT: go to DONE.
- ISSUE (1 cycle):
  - mode/rx/ry/rz hold the issued values; the datapath executes on this cycle's closing edge.
  - At that edge mode, rx, ry and rz clear to 0.
  - Go to CAPTURE.
- CAPTURE (1 cycle):
  - carry_flag <= cy.
  - Advance pc, go to FETCH.
- Advancing pc:
  - If pc = PROG_DEPTH-1, go to DONE instead; there is no wrap-around. pc holds at PROG_DEPTH-1.
  - A taken JC is not an advance, so it is never subject to this rule.
- DONE (1 cycle): done=1, then go to IDLE. pc and carry_flag hold until the next start.
- Timing:
  - A datapath op costs 3 cycles. NOP and JC cost 1 cycle each. HALT costs 1 cycle plus the DONE cycle.
  - mode is nonzero for exactly one cycle per datapath op and is 0 at all other times.
- start while busy or in DONE is ignored.
- Reset mid-program: mode clears immediately, with no partial operation repeated; the program memory is cleared as well.
- JC with a target of the JC's own address and carry_flag=1 loops forever. This is legal, and only rst exits it.

Test Plan:
- Reset check: assert rst mid-stream -> mode=0, rx=ry=rz=0, busy=0, done=0, pc=0, carry_flag=0; mem[0..15] read back as NOP.
- Straight-line program: load 0x189A, 0x2AB6, 0xF000, then pulse start at edge 0:
  - cycle 2: mode=1, rx=8, ry=9, rz=A, for one cycle only.
  - cycle 5: mode=2, rx=A, ry=B, rz=6.
  - cycle 8: done=1.
  - cycle 9: back in IDLE with busy=0.
- Branch on carry: program 0x1123, 0xE003, 0xF000, 0x2456, 0xF000:
  - Bench drives cy=1 during CAPTURE -> op 2 is issued (rx=4, ry=5, rz=6) and carry_flag=1 at end.
  - Repeat with cy=0 -> no second issue; done after pc 2.
- All-NOP program: after reset, start -> 16 consecutive FETCH cycles with mode=0, then DONE; pc=15 at done.
- Ignored requests: start and prog_we pulsed during ISSUE -> no restart, program word unchanged. The same prog_we pulse in IDLE writes the word.
- Reset mid-ISSUE: assert rst while mode=1 -> mode=0 before the next edge; a fresh load plus start runs normally from pc 0.
